// File: rtl/serial_subtractor_nbit_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_nbit_if
// Purpose  : Request/result bundle for the serial ripple-borrow subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_nbit_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 borrow_in;
  logic [BIT_WIDTH-1:0] diff;
  logic                 borrow_out;
  logic                 overflow;
  logic                 busy;
  logic                 done;

  modport master (
    output start, a, b, borrow_in,
    input  diff, borrow_out, overflow, busy, done
  );

  modport slave (
    input  start, a, b, borrow_in,
    output diff, borrow_out, overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_nbit.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_nbit
// Purpose  : Multi-cycle diff = a - b - borrow_in, CHUNK bits per BUSY cycle.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor_nbit #(
  parameter int BIT_WIDTH = 16,
  parameter int CHUNK     = 1
) (
  input wire                      clk,
  input wire                      rst,
  serial_subtractor_nbit_if.slave bus
);

  localparam int N     = BIT_WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = BIT_WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((CHUNK < 1) || ((BIT_WIDTH % CHUNK) != 0)) begin : g_param_check
    $fatal(1, "serial_subtractor_nbit: BIT_WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_WIDTH-1:0] r_a;
  logic [BIT_WIDTH-1:0] r_b;
  logic                 r_borrow;
  logic [BIT_WIDTH-1:0] r_diff_sh;
  logic [BIT_WIDTH-1:0] r_diff;
  logic                 r_borrow_out;
  logic                 r_overflow;

  logic                 w_accept;
  logic                 w_last;
  logic [CHUNK-1:0]     w_a_chunk;
  logic [CHUNK-1:0]     w_b_chunk;
  logic [CHUNK:0]       w_sub;
  logic [BIT_WIDTH-1:0] w_diff_next;

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CNT_W'(N - 1));

  // Operands stay intact; the counter selects which slice is being resolved.
  assign w_a_chunk = CHUNK'(r_a >> (r_cnt * CHUNK));
  assign w_b_chunk = CHUNK'(r_b >> (r_cnt * CHUNK));
  assign w_sub     = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};

  // Result slices enter at the top, so after N shifts the first slice sits at the LSBs.
  assign w_diff_next = (r_diff_sh >> CHUNK) |
                       (BIT_WIDTH'(w_sub[CHUNK-1:0]) << (BIT_WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_borrow     <= 1'b0;
      r_diff_sh    <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.borrow_in;
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_borrow  <= w_sub[CHUNK];
          r_diff_sh <= w_diff_next;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff       <= w_diff_next;
            r_borrow_out <= w_sub[CHUNK];
            r_overflow   <= (r_a[MSB] != r_b[MSB]) && (w_diff_next[MSB] != r_a[MSB]);
            r_state      <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
  assign bus.overflow   = r_overflow;
  assign bus.busy       = (r_state == S_BUSY);
  assign bus.done       = (r_state == S_DONE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && w_accept) begin
      assert (!$isunknown({bus.a, bus.b, bus.borrow_in}))
        else $error("serial_subtractor_nbit: unknown operand bits on accepted start");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor_nbit
// Purpose  : Directed self-checking bench for serial_subtractor_nbit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_nbit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_nbit_if #(.BIT_WIDTH(16)) bus ();
  serial_subtractor_nbit_if #(.BIT_WIDTH(16)) bus4 ();

  serial_subtractor_nbit #(.BIT_WIDTH(16), .CHUNK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_subtractor_nbit #(.BIT_WIDTH(16), .CHUNK(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch on the CHUNK=1 unit from a negedge; optionally keep start high with
  // junk operands for the first 'hold' BUSY cycles. Returns in the done cycle.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_op, input logic tbin,
                       input int hold, output int cyc, output int nbusy);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_op; bus.borrow_in = tbin;
    cyc = 0; nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc <= hold) begin
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000; bus.borrow_in = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) nbusy++;
    end while (!bus.done && cyc < 40);
  endtask

  task automatic check_res(input string tag, input logic [15:0] d, input logic bo, input logic ov);
    check_eq({tag, "_diff"}, 32'(bus.diff), 32'(d));
    check_eq({tag, "_bo"},   32'(bus.borrow_out), 32'(bo));
    check_eq({tag, "_ov"},   32'(bus.overflow), 32'(ov));
  endtask

  initial begin
    int cyc;
    int nb;
    int seen;
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.borrow_in = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_diff", 32'(bus.diff), 32'h0);
    check_eq("rst_bo",   32'(bus.borrow_out), 32'h0);
    check_eq("rst_ov",   32'(bus.overflow), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: latency and basic result
    do_op(16'h1234, 16'h0234, 1'b0, 0, cyc, nb);
    check_eq("t1_cycles", 32'(cyc), 32'd17);
    check_eq("t1_busy",   32'(nb), 32'd16);
    check_res("t1", 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(bus.done), 32'h0);
    check_eq("t1_hold_diff",  32'(bus.diff), 32'h1000);

    // T2/T3: underflow and signed overflow corners
    do_op(16'h0000, 16'h0001, 1'b0, 0, cyc, nb);
    check_res("t2", 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    do_op(16'h8000, 16'h0001, 1'b0, 0, cyc, nb);
    check_res("t3a", 16'h7FFF, 1'b0, 1'b1);
    @(negedge clk);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, cyc, nb);
    check_res("t3b", 16'h8000, 1'b1, 1'b1);
    @(negedge clk);

    // T4: borrow_in participates
    do_op(16'h0005, 16'h0005, 1'b1, 0, cyc, nb);
    check_res("t4", 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);

    // T4: start held during BUSY with different operands is ignored
    bus.start = 1'b1; bus.a = 16'h0010; bus.b = 16'h0003; bus.borrow_in = 1'b0;
    @(negedge clk);
    check_eq("t4_prev_held", 32'(bus.diff), 32'hFFFF);
    do_op(16'hFFFF, 16'h0000, 1'b1, 10, cyc, nb);
    check_eq("t4_hold_cycles", 32'(cyc), 32'd16);
    check_res("t4_hold", 16'h000D, 1'b0, 1'b0);

    // T4: back-to-back start in the DONE cycle
    do_op(16'h1000, 16'h0001, 1'b1, 0, cyc, nb);
    check_eq("t4_b2b_cycles", 32'(cyc), 32'd17);
    check_eq("t4_b2b_busy",   32'(nb), 32'd16);
    check_res("t4_b2b", 16'h0FFE, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t4_idle_busy", 32'(bus.busy), 32'h0);

    // T5: asynchronous reset mid-BUSY
    bus.start = 1'b1; bus.a = 16'h0100; bus.b = 16'h0001; bus.borrow_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("t5_busy_before", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_diff", 32'(bus.diff), 32'h0);
    check_eq("t5_busy", 32'(bus.busy), 32'h0);
    check_eq("t5_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq("t5_no_done", 32'(seen), 32'h0);
    do_op(16'h0100, 16'h0001, 1'b0, 0, cyc, nb);
    check_eq("t5_cycles", 32'(cyc), 32'd17);
    check_res("t5", 16'h00FF, 1'b0, 1'b0);
    @(negedge clk);

    // T6: CHUNK=4 instance
    bus4.start = 1'b1; bus4.a = 16'hABCD; bus4.b = 16'h1234; bus4.borrow_in = 1'b0;
    cyc = 0; nb = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus4.start = 1'b0;
      if (bus4.busy) nb++;
    end while (!bus4.done && cyc < 40);
    check_eq("t6_cycles", 32'(cyc), 32'd5);
    check_eq("t6_busy",   32'(nb), 32'd4);
    check_eq("t6_diff",   32'(bus4.diff), 32'h9999);
    check_eq("t6_bo",     32'(bus4.borrow_out), 32'h0);
    check_eq("t6_ov",     32'(bus4.overflow), 32'h0);

    // CHUNK=4 borrow must ripple across all slices
    bus4.start = 1'b1; bus4.a = 16'h0000; bus4.b = 16'h0001; bus4.borrow_in = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus4.start = 1'b0;
    end while (!bus4.done && cyc < 40);
    check_eq("t6b_cycles", 32'(cyc), 32'd5);
    check_eq("t6b_diff",   32'(bus4.diff), 32'hFFFF);
    check_eq("t6b_bo",     32'(bus4.borrow_out), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
